// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store memory front end.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_X = 2'd3
    } lsu_size_e;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [3:0] LANE_B = 4'b0001;
    localparam logic [3:0] LANE_H = 4'b0011;
    localparam logic [3:0] LANE_W = 4'b1111;

    // Halves must sit on even bytes and words on word boundaries; bytes never misalign.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SZ_H:    mis = off[0];
            SZ_W:    mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store mask/data shifting and load extract/extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic        wen,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);

    logic [4:0]  sh;
    logic [31:0] rshift;

    always_comb begin
        sh       = {offset, 3'b000};
        wdata_sh = wdata << sh;
        rshift   = rdata >> sh;

        wmask = 4'b0000;
        if (wen) begin
            case (size)
                SZ_B:    wmask = LANE_B << offset;
                SZ_H:    wmask = LANE_H << offset;
                SZ_W:    wmask = LANE_W;
                default: wmask = 4'b0000;
            endcase
        end

        case (size)
            SZ_B:    rdata_ext = {{24{sign_ext & rshift[7]}}, rshift[7:0]};
            SZ_H:    rdata_ext = {{16{sign_ext & rshift[15]}}, rshift[15:0]};
            default: rdata_ext = rshift;
        endcase
    end

endmodule

// File: rtl/lsu_mem_frontend.sv
// Single-outstanding load/store front end feeding a one-cycle memory port,
// with an optional latency counter in front of the access.
module lsu_mem_frontend
    import lsu_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    output logic        mem_wen,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             wen_q;
    logic             signed_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [1:0]       size_q;
    logic [3:0]       wmask;
    logic [31:0]      wdata_sh;
    logic [31:0]      rdata_ext;

    lsu_lane_align u_align (
        .wen      (wen_q),
        .size     (size_q),
        .offset   (addr_q[1:0]),
        .sign_ext (signed_q),
        .wdata    (wdata_q),
        .rdata    (mem_rdata),
        .wmask    (wmask),
        .wdata_sh (wdata_sh),
        .rdata_ext(rdata_ext)
    );

    // Bad requests bypass memory entirely and answer straight from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            wen_q      <= 1'b0;
            signed_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= 2'b00;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        wen_q    <= req_wen;
                        signed_q <= req_signed;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        size_q   <= req_size;
                        if (req_size == SZ_X || is_misaligned(req_size, req_addr[1:0])) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= ST_RESP;
                        end else if (WAIT_CYCLES == 0) begin
                            state <= ST_ACCESS;
                        end else begin
                            cnt   <= CNT_W'(WAIT_CYCLES);
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    resp_err   <= 1'b0;
                    resp_rdata <= wen_q ? 32'h0 : rdata_ext;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Strobes decode straight from the state register so they cannot glitch.
    always_comb begin
        req_ready  = (state == ST_IDLE);
        resp_valid = (state == ST_RESP);
        mem_valid  = (state == ST_ACCESS);
        mem_wen    = (state == ST_ACCESS) & wen_q;
        mem_raddr  = {addr_q[31:2], 2'b00};
        mem_waddr  = {addr_q[31:2], 2'b00};
        mem_wdata  = wdata_sh;
        mem_wmask  = {4'b0000, wmask};
    end

endmodule

// File: tb/tb_lsu_mem_frontend.sv
// Bench for lsu_mem_frontend: one instance with no wait states, one with three.
module tb_lsu_mem_frontend;

    typedef struct {
        int          d;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] rword;
        int          stall;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_mask;
        logic [31:0] exp_wdata;
        logic [31:0] exp_waddr;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid, req_ready, req_wen, req_signed;
    logic [1:0][31:0] req_addr, req_wdata;
    logic [1:0][1:0]  req_size;
    logic [1:0]       resp_valid, resp_ready, resp_err;
    logic [1:0][31:0] resp_rdata;
    logic [1:0]       mem_valid, mem_wen;
    logic [1:0][31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic [1:0][7:0]  mem_wmask;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt0  = 0;
    int wr_cnt1  = 0;

    int          obs_mcount, obs_acc, obs_resp, obs_busy_ready, obs_unstable;
    logic        obs_err, obs_wen, obs_after_valid, obs_after_ready;
    logic [31:0] obs_rdata, obs_wdata, obs_waddr, obs_raddr;
    logic [7:0]  obs_mask;

    lsu_mem_frontend #(.WAIT_CYCLES(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_size(req_size[0]),
        .req_signed(req_signed[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .mem_valid(mem_valid[0]),
        .mem_wen(mem_wen[0]), .mem_raddr(mem_raddr[0]), .mem_waddr(mem_waddr[0]),
        .mem_wdata(mem_wdata[0]), .mem_wmask(mem_wmask[0]), .mem_rdata(mem_rdata[0])
    );

    lsu_mem_frontend #(.WAIT_CYCLES(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_size(req_size[1]),
        .req_signed(req_signed[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .mem_valid(mem_valid[1]),
        .mem_wen(mem_wen[1]), .mem_raddr(mem_raddr[1]), .mem_waddr(mem_waddr[1]),
        .mem_wdata(mem_wdata[1]), .mem_wmask(mem_wmask[1]), .mem_rdata(mem_rdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count writes actually committed to memory at a clock edge.
    always @(posedge clk) begin
        if (mem_valid[0] && mem_wen[0]) wr_cnt0 <= wr_cnt0 + 1;
        if (mem_valid[1] && mem_wen[1]) wr_cnt1 <= wr_cnt1 + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(input int d, input logic wen, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [1:0] size, input logic sgn,
                                   input logic [31:0] rword, input int stall, input logic err,
                                   input logic [31:0] rdata, input logic [7:0] mask,
                                   input logic [31:0] wdata_e, input logic [31:0] waddr);
        vec_t v;
        v.d = d; v.wen = wen; v.addr = addr; v.wdata = wdata; v.size = size; v.sgn = sgn;
        v.rword = rword; v.stall = stall; v.exp_err = err; v.exp_rdata = rdata;
        v.exp_mask = mask; v.exp_wdata = wdata_e; v.exp_waddr = waddr;
        return v;
    endfunction

    // Reference: access width in bytes, alignment by modulo, lanes by arithmetic.
    function automatic vec_t withModel(input vec_t v);
        vec_t   r;
        int     o, n;
        longint val, lim;
        r = v;
        o = int'(v.addr % 4);
        n = 1 << v.size;
        r.exp_err   = (v.size == 2'd3) || ((o % n) != 0);
        r.exp_waddr = v.addr - 32'(o);
        r.exp_mask  = v.wen ? 8'(((1 << n) - 1) << o) : 8'h00;
        r.exp_wdata = 32'(longint'(v.wdata) * (longint'(1) << (8 * o)));
        r.exp_rdata = 32'h0;
        if (!r.exp_err && !v.wen) begin
            lim = longint'(1) << (8 * n);
            val = (longint'(v.rword) / (longint'(1) << (8 * o))) % lim;
            if (v.sgn && n < 4 && val >= lim / 2) val = val - lim;
            r.exp_rdata = 32'(val);
        end
        return r;
    endfunction

    task automatic applyStimulus(input vec_t v);
        int d, cyc;
        d = v.d;
        @(negedge clk);
        mem_rdata[d]  = v.rword;
        req_wen[d]    = v.wen;
        req_addr[d]   = v.addr;
        req_wdata[d]  = v.wdata;
        req_size[d]   = v.size;
        req_signed[d] = v.sgn;
        req_valid[d]  = 1'b1;
        checkOutput("req_ready_idle", 32'(req_ready[d]), 32'd1);
        @(negedge clk);
        req_valid[d] = 1'b0;
        obs_mcount = 0; obs_acc = -1; obs_resp = -1; obs_busy_ready = 0; obs_unstable = 0;
        obs_err = 1'b0; obs_rdata = '0; obs_wen = 1'b0;
        obs_mask = '0; obs_wdata = '0; obs_waddr = '0; obs_raddr = '0;
        cyc = 1;
        while (obs_resp < 0 && cyc <= 40) begin
            if (mem_valid[d]) begin
                obs_mcount++;
                obs_acc   = cyc;
                obs_wen   = mem_wen[d];
                obs_mask  = mem_wmask[d];
                obs_wdata = mem_wdata[d];
                obs_waddr = mem_waddr[d];
                obs_raddr = mem_raddr[d];
            end
            if (req_ready[d]) obs_busy_ready++;
            if (resp_valid[d]) begin
                obs_resp  = cyc;
                obs_err   = resp_err[d];
                obs_rdata = resp_rdata[d];
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        for (int k = 0; k < v.stall; k++) begin
            @(negedge clk);
            if (resp_valid[d] !== 1'b1 || resp_rdata[d] !== obs_rdata ||
                resp_err[d] !== obs_err || req_ready[d] !== 1'b0 || mem_valid[d] !== 1'b0)
                obs_unstable++;
        end
        resp_ready[d] = 1'b1;
        @(negedge clk);
        resp_ready[d]   = 1'b0;
        obs_after_valid = resp_valid[d];
        obs_after_ready = req_ready[d];
    endtask

    task automatic verifyTxn(input vec_t v, input string tag);
        int w;
        w = (v.d == 1) ? 3 : 0;
        checkOutput({tag, ".err"}, 32'(obs_err), 32'(v.exp_err));
        checkOutput({tag, ".rdata"}, obs_rdata, v.exp_rdata);
        if (v.exp_err) begin
            checkOutput({tag, ".resp_lat"}, 32'(obs_resp), 32'd1);
            checkOutput({tag, ".mem_count"}, 32'(obs_mcount), 32'd0);
        end else begin
            checkOutput({tag, ".resp_lat"}, 32'(obs_resp), 32'(w + 2));
            checkOutput({tag, ".mem_count"}, 32'(obs_mcount), 32'd1);
            checkOutput({tag, ".acc_lat"}, 32'(obs_acc), 32'(w + 1));
            checkOutput({tag, ".mem_wen"}, 32'(obs_wen), 32'(v.wen));
            checkOutput({tag, ".waddr"}, obs_waddr, v.exp_waddr);
            checkOutput({tag, ".raddr"}, obs_raddr, v.exp_waddr);
            checkOutput({tag, ".wmask"}, 32'(obs_mask), 32'(v.exp_mask));
            if (v.wen) checkOutput({tag, ".wdata"}, obs_wdata, v.exp_wdata);
        end
        checkOutput({tag, ".ready_busy"}, 32'(obs_busy_ready), 32'd0);
        checkOutput({tag, ".stall_stable"}, 32'(obs_unstable), 32'd0);
        checkOutput({tag, ".valid_after"}, 32'(obs_after_valid), 32'd0);
        checkOutput({tag, ".ready_after"}, 32'(obs_after_ready), 32'd1);
    endtask

    vec_t vecs[12];
    vec_t rv;
    int   wr_before;

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_wen = '0; req_signed = '0; req_addr = '0; req_wdata = '0;
        req_size = '0; resp_ready = '0; mem_rdata = '0;

        vecs[0]  = mkVec(0, 1, 32'h8000_0004, 32'hDEAD_BEEF, 2, 0, 32'h0, 0, 0, 32'h0, 8'h0F, 32'hDEAD_BEEF, 32'h8000_0004);
        vecs[1]  = mkVec(0, 1, 32'h8000_0003, 32'h0000_00AB, 0, 0, 32'h0, 0, 0, 32'h0, 8'h08, 32'hAB00_0000, 32'h8000_0000);
        vecs[2]  = mkVec(0, 0, 32'h8000_0002, 32'h0, 1, 1, 32'h8001_1234, 0, 0, 32'hFFFF_8001, 8'h00, 32'h0, 32'h8000_0000);
        vecs[3]  = mkVec(0, 0, 32'h8000_0002, 32'h0, 1, 0, 32'h8001_1234, 0, 0, 32'h0000_8001, 8'h00, 32'h0, 32'h8000_0000);
        vecs[4]  = mkVec(0, 0, 32'h8000_0001, 32'h0, 0, 1, 32'h0000_80FF, 1, 0, 32'hFFFF_FF80, 8'h00, 32'h0, 32'h8000_0000);
        vecs[5]  = mkVec(0, 0, 32'h8000_0002, 32'h0, 2, 0, 32'h1111_1111, 0, 1, 32'h0, 8'h00, 32'h0, 32'h0);
        vecs[6]  = mkVec(0, 0, 32'h8000_0000, 32'h0, 3, 0, 32'h1111_1111, 0, 1, 32'h0, 8'h00, 32'h0, 32'h0);
        vecs[7]  = mkVec(1, 0, 32'h8000_0008, 32'h0, 2, 0, 32'h1234_5678, 5, 0, 32'h1234_5678, 8'h00, 32'h0, 32'h8000_0008);
        vecs[8]  = mkVec(0, 1, 32'h8000_000A, 32'hCAFE_1234, 1, 0, 32'h0, 0, 0, 32'h0, 8'h0C, 32'h1234_0000, 32'h8000_0008);
        vecs[9]  = mkVec(1, 1, 32'h8000_0001, 32'h0000_5555, 1, 0, 32'h0, 2, 1, 32'h0, 8'h00, 32'h0, 32'h0);
        vecs[10] = mkVec(1, 0, 32'h8000_0003, 32'h0, 0, 0, 32'hA500_0000, 0, 0, 32'h0000_00A5, 8'h00, 32'h0, 32'h8000_0000);
        vecs[11] = mkVec(0, 0, 32'h8000_0010, 32'h0, 2, 1, 32'h8000_0000, 0, 0, 32'h8000_0000, 8'h00, 32'h0, 32'h8000_0010);

        #12;
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst.req_ready", 32'(req_ready[d]), 32'd1);
            checkOutput("rst.resp_valid", 32'(resp_valid[d]), 32'd0);
            checkOutput("rst.resp_err", 32'(resp_err[d]), 32'd0);
            checkOutput("rst.resp_rdata", resp_rdata[d], 32'd0);
            checkOutput("rst.mem_valid", 32'(mem_valid[d]), 32'd0);
            checkOutput("rst.mem_wen", 32'(mem_wen[d]), 32'd0);
            checkOutput("rst.mem_addr", mem_raddr[d] | mem_waddr[d], 32'd0);
            checkOutput("rst.mem_wdata", mem_wdata[d], 32'd0);
            checkOutput("rst.mem_wmask", 32'(mem_wmask[d]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            verifyTxn(vecs[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 60; i++) begin
            rv.d     = int'($urandom_range(0, 1));
            rv.wen   = 1'($urandom_range(0, 1));
            rv.addr  = $urandom;
            rv.wdata = $urandom;
            rv.size  = 2'($urandom_range(0, 3));
            rv.sgn   = 1'($urandom_range(0, 1));
            rv.rword = $urandom;
            rv.stall = int'($urandom_range(0, 2));
            rv = withModel(rv);
            applyStimulus(rv);
            verifyTxn(rv, $sformatf("rnd%0d", i));
        end

        // Reset while the three-wait instance is counting down on a store.
        @(negedge clk);
        req_wen[1] = 1'b1; req_addr[1] = 32'h8000_0020; req_wdata[1] = 32'hFFFF_FFFF;
        req_size[1] = 2'd2; req_valid[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        wr_before = wr_cnt1;
        @(negedge clk);
        checkOutput("rstwait.ready_before", 32'(req_ready[1]), 32'd0);
        checkOutput("rstwait.mask_before", 32'(mem_wmask[1]), 32'h0F);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstwait.req_ready", 32'(req_ready[1]), 32'd1);
        checkOutput("rstwait.mem_valid", 32'(mem_valid[1]), 32'd0);
        checkOutput("rstwait.mem_wmask", 32'(mem_wmask[1]), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rstwait.no_write", 32'(wr_cnt1), 32'(wr_before));
        checkOutput("rstwait.ready_after", 32'(req_ready[1]), 32'd1);
        rv = withModel(mkVec(1, 0, 32'h8000_0024, 32'h0, 0, 1, 32'h0000_7F00, 0, 0, 0, 0, 0, 0));
        applyStimulus(rv);
        verifyTxn(rv, "rstwait.next");

        // Reset landing in the middle of the access cycle of a store.
        @(negedge clk);
        req_wen[0] = 1'b1; req_addr[0] = 32'h8000_0030; req_wdata[0] = 32'h1122_3344;
        req_size[0] = 2'd2; req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        wr_before = wr_cnt0;
        checkOutput("rstacc.mem_valid_before", 32'(mem_valid[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstacc.mem_valid", 32'(mem_valid[0]), 32'd0);
        checkOutput("rstacc.mem_wen", 32'(mem_wen[0]), 32'd0);
        checkOutput("rstacc.mem_wdata", mem_wdata[0], 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rstacc.no_write", 32'(wr_cnt0), 32'(wr_before));
        checkOutput("rstacc.ready_after", 32'(req_ready[0]), 32'd1);
        rv = withModel(mkVec(0, 1, 32'h8000_0032, 32'h0000_BEEF, 1, 0, 32'h0, 1, 0, 0, 0, 0, 0));
        applyStimulus(rv);
        verifyTxn(rv, "rstacc.next");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_frontend.md
Name: lsu_mem_frontend

Overview:
Load/store front end sitting directly upstream of the DPI memory controller in the NPC core. It accepts one load or store request at a time from the execute stage over a valid/ready handshake. It word-aligns the address, builds the byte write mask and shifted write data, and issues a single one-cycle access to the memory controller. It then extracts and sign- or zero-extends load data and returns it over a valid/ready response channel. An optional wait counter models memory latency so the pipeline can be exercised with multi-cycle memory.

Parameters:
WAIT_CYCLES, 0, extra idle cycles inserted between request acceptance and the memory access (0..15)
CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > WAIT_CYCLES

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  execute stage presents a request
req_ready  output  1  frontend can accept a request
req_wen  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_signed  input  1  load sign-extends when 1
resp_valid  output  1  response available
resp_ready  input  1  consumer takes response
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned access or illegal size
mem_valid  output  1  memory access strobe
mem_wen  output  1  memory write enable
mem_raddr  output  32  word-aligned read address
mem_waddr  output  32  word-aligned write address
mem_wdata  output  32  lane-shifted write data
mem_wmask  output  8  byte mask; bits [7:4] always 0
mem_rdata  input  32  read word, valid in the same cycle as mem_valid & ~mem_wen

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State returns to IDLE.
  - req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_valid=0, mem_wen=0.
  - All mem address, data and mask outputs = 0.
  - Any in-flight access is abandoned and no write is issued.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch wen, addr, wdata, size and signed.
  - If the access is misaligned or illegal, go to RESP with err=1. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0. Illegal means size=3.
  - Otherwise go to WAIT, loading the counter with WAIT_CYCLES.
  - WAIT is skipped, going straight to ACCESS, when WAIT_CYCLES=0.
- WAIT:
  - Counter decrements each cycle.
  - Go to ACCESS in the cycle after the counter reaches 1.
- ACCESS:
  - mem_valid=1 for exactly one cycle; mem_wen = latched wen.
  - For loads, capture the extracted and extended mem_rdata at the cycle-ending edge.
  - Go to RESP.
- RESP:
  - resp_valid=1; hold rdata and err stable until resp_ready.
  - On resp_ready, return to IDLE.
  - req_ready is 0 in RESP: no same-cycle turnaround.
- req_ready is 0 in WAIT, ACCESS and RESP.
- Latency with WAIT_CYCLES=0: accepted at edge E, ACCESS in cycle E+1, resp_valid from cycle E+2. Each WAIT cycle adds one.
- Address: mem_raddr = mem_waddr = {addr[31:2],2'b00}, driven from the latch and stable from ACCESS onward.
- Write mask, with o = addr[1:0]:
  - byte: 4'b0001<<o
  - half: 4'b0011<<o
  - word: 4'b1111
  - mask is 0 on loads.
- Write data: mem_wdata = req_wdata << (8*o); upper lanes beyond the shift are 0.
- Load extract: shift mem_rdata right by 8*o, keep 8, 16 or 32 bits, then sign- or zero-extend per req_signed. For word loads the signed flag has no effect.
- mem_valid is decoded from the state register only, so it is glitch-free and never asserted outside ACCESS.
- Error responses never assert mem_valid.
- resp_ready held low indefinitely: the block stalls in RESP; no request is lost or duplicated.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_B, SZ_H, SZ_W
  - FSM state enum
  - lane mask constants
  - function is_misaligned(size, addr)
- Sub-module lsu_lane_align (combinational):
  - store side: produces wmask and shifted wdata
  - load side: performs extract and extension
- lsu_mem_frontend keeps the FSM, request latch, counter and response register.

Test Plan:
1. WAIT_CYCLES=0. Store word 0xDEADBEEF to 0x80000004 -> ACCESS one cycle after accept; mem_waddr=0x80000004, mem_wmask=0x0F, mem_wen=1. resp_valid the next cycle with rdata=0, err=0.
2. Store byte 0xAB to 0x80000003 -> mem_wmask=0x08, mem_wdata=0xAB000000, mem_waddr=0x80000000.
3. Load half, signed, addr 0x80000002, mem_rdata=0x8001_1234 -> resp_rdata=0xFFFF8001. The same access unsigned -> 0x00008001. Load byte signed at offset 1 of 0x000080FF -> 0xFFFFFF80.
4. Load word at 0x80000002 -> resp_err=1, mem_valid never asserted, resp_valid the cycle after accept. size=3 at an aligned address -> same result.
5. WAIT_CYCLES=3. Load word -> mem_valid asserted exactly at accept+4 for one cycle. resp_ready held low 5 cycles -> resp_valid and rdata stable, req_ready=0 throughout.
6. Assert rst_n low during WAIT, then during ACCESS -> mem_valid drops immediately, no write issued, req_ready=1 after release, and the next request completes normally.
